// File: rtl/usb_rx_dma_if.sv
// Bundle of CPU register window, CPU/memory bus and USB/ACIA rx stream signals.
// Latency: none; this is wiring only.
// Backpressure: rx stream uses val/rdy; the CPU side is held off with cpu_rdy.
interface usb_rx_dma_if;
  // CPU register window
  logic        cs;
  logic        we;
  logic [2:0]  rs;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        irq;
  // CPU bus in, memory decode bus out
  logic [15:0] cpu_ab;
  logic        cpu_we;
  logic [7:0]  cpu_do;
  logic        cpu_rdy;
  logic [15:0] mem_ab;
  logic        mem_we;
  logic [7:0]  mem_do;
  // USB rx stream and ACIA forward path
  logic [7:0]  rx_data;
  logic        rx_val;
  logic        rx_rdy;
  logic        acia_rx_val;
  logic        acia_rx_rdy;

  // DMA block side
  modport slave (
    input  cs, we, rs, din, cpu_ab, cpu_we, cpu_do, rx_data, rx_val, acia_rx_rdy,
    output dout, irq, cpu_rdy, mem_ab, mem_we, mem_do, rx_rdy, acia_rx_val
  );

  // System side (CPU, memory decode, USB core, ACIA)
  modport master (
    output cs, we, rs, din, cpu_ab, cpu_we, cpu_do, rx_data, rx_val, acia_rx_rdy,
    input  dout, irq, cpu_rdy, mem_ab, mem_we, mem_do, rx_rdy, acia_rx_val
  );
endinterface

// File: rtl/usb_rx_dma.sv
// Cycle-stealing DMA: USB rx bytes are written straight into 6502 RAM.
// Latency: rx accept -> RAM write next cycle; 2 stalled CPU cycles per byte, 1 byte / 3 clk peak.
// Backpressure: rx_rdy high only while waiting for a byte; CPU stalled via cpu_rdy during WRITE/RESTORE.
module usb_rx_dma #(
  parameter logic [15:0] ADDR_LIMIT = 16'hD000
) (
  input logic          clk,
  input logic          rst,
  usb_rx_dma_if.slave  dma_if
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_WRITE   = 2'd2,
    S_RESTORE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] len_q, len_d;
  logic        ie_q, ie_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        abort_q, abort_d;
  logic [7:0]  buf_q, buf_d;
  logic [7:0]  dout_q, dout_d;

  logic        busy;
  logic        cpu_rdy_w;
  logic        reg_wr;
  logic        reg_rd;
  logic        ctrl_wr;
  logic        start_req;
  logic        abort_req;
  logic        stall_abort;
  logic        rx_rdy_w;
  logic        acia_val_w;
  logic [15:0] mem_ab_w;
  logic        mem_we_w;
  logic [7:0]  mem_do_w;

  assign busy      = (state_q != S_IDLE);
  // The CPU is only held off while the stolen slot (WRITE + RESTORE) owns the bus.
  assign cpu_rdy_w = !((state_q == S_WRITE) || (state_q == S_RESTORE));

  assign reg_wr    = dma_if.cs & dma_if.we & cpu_rdy_w;
  assign reg_rd    = dma_if.cs & ~dma_if.we & cpu_rdy_w;
  assign ctrl_wr   = reg_wr & (dma_if.rs == 3'd4);
  // ABORT beats START when both bits are written together.
  assign abort_req = ctrl_wr & dma_if.din[2];
  assign start_req = ctrl_wr & dma_if.din[0] & ~dma_if.din[2];
  // A stalled CPU keeps presenting its ABORT write; catch it so the current pair ends the transfer.
  assign stall_abort = ~cpu_rdy_w & dma_if.cs & dma_if.we & (dma_if.rs == 3'd4) & dma_if.din[2];

  // Bus ownership and rx routing decoded from state and live inputs.
  always_comb begin
    mem_ab_w   = dma_if.cpu_ab;
    mem_we_w   = dma_if.cpu_we;
    mem_do_w   = dma_if.cpu_do;
    rx_rdy_w   = dma_if.acia_rx_rdy;
    acia_val_w = dma_if.rx_val;
    case (state_q)
      S_IDLE: begin
        // Defaults: CPU owns the bus and rx goes to the ACIA.
      end
      S_WAIT: begin
        // Refuse the byte on the abort edge so it is not silently dropped.
        rx_rdy_w   = ~abort_req;
        acia_val_w = 1'b0;
      end
      S_WRITE: begin
        mem_ab_w   = addr_q;
        mem_we_w   = 1'b1;
        mem_do_w   = buf_q;
        rx_rdy_w   = 1'b0;
        acia_val_w = 1'b0;
      end
      S_RESTORE: begin
        // Re-present the stalled CPU address so read data is valid on resume.
        mem_we_w   = 1'b0;
        rx_rdy_w   = 1'b0;
        acia_val_w = 1'b0;
      end
      default: begin
        rx_rdy_w   = 1'b0;
        acia_val_w = 1'b0;
      end
    endcase
  end

  // Next-state: transfer sequencing, then CPU register writes and reads.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    ie_d    = ie_q;
    done_d  = done_q;
    err_d   = err_q;
    abort_d = abort_q;
    buf_d   = buf_q;
    dout_d  = dout_q;

    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          if (len_q == 16'h0000) begin
            done_d = 1'b1;
          end else if (addr_q >= ADDR_LIMIT) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (abort_req) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (dma_if.rx_val && rx_rdy_w) begin
          buf_d   = dma_if.rx_data;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + 16'd1;
        len_d   = (len_q != 16'h0000) ? (len_q - 16'd1) : 16'h0000;
        abort_d = abort_q | stall_abort;
        state_d = S_RESTORE;
      end
      S_RESTORE: begin
        // addr_q/len_q already hold the post-increment values here.
        abort_d = 1'b0;
        if (len_q == 16'h0000) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (addr_q >= ADDR_LIMIT) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          done_d  = 1'b1;
        end else if (abort_q || stall_abort) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (reg_wr) begin
      case (dma_if.rs)
        3'd0: if (!busy) addr_d[7:0]  = dma_if.din;
        3'd1: if (!busy) addr_d[15:8] = dma_if.din;
        3'd2: if (!busy) len_d[7:0]   = dma_if.din;
        3'd3: if (!busy) len_d[15:8]  = dma_if.din;
        3'd4: ie_d = dma_if.din[1];
        3'd5: begin
          done_d = 1'b0;
          err_d  = 1'b0;
        end
        default: begin
        end
      endcase
    end

    if (reg_rd) begin
      case (dma_if.rs)
        3'd0:    dout_d = addr_q[7:0];
        3'd1:    dout_d = addr_q[15:8];
        3'd2:    dout_d = len_q[7:0];
        3'd3:    dout_d = len_q[15:8];
        3'd4:    dout_d = {5'b0, 1'b0, ie_q, busy};
        3'd5:    dout_d = {done_q, err_q, 5'b0, busy};
        default: dout_d = 8'h00;
      endcase
    end
  end

  // State and register file update, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= 16'h0000;
      len_q   <= 16'h0000;
      ie_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
      buf_q   <= 8'h00;
      dout_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      ie_q    <= ie_d;
      done_q  <= done_d;
      err_q   <= err_d;
      abort_q <= abort_d;
      buf_q   <= buf_d;
      dout_q  <= dout_d;
    end
  end

  assign dma_if.cpu_rdy     = cpu_rdy_w;
  assign dma_if.mem_ab      = mem_ab_w;
  assign dma_if.mem_we      = mem_we_w;
  assign dma_if.mem_do      = mem_do_w;
  assign dma_if.rx_rdy      = rx_rdy_w;
  assign dma_if.acia_rx_val = acia_val_w;
  assign dma_if.dout        = dout_q;
  assign dma_if.irq         = ie_q & done_q;

endmodule

// File: doc/usb_rx_dma.md
# usb_rx_dma

Cycle-stealing DMA controller that moves bytes from the USB CDC receive stream (MUACM AXI-style rx port) straight into 6502 RAM, bypassing the byte-at-a-time ACIA path. It sits between the CPU core and the memory decode. It owns the shared RAM bus for short stolen slots by pulling the CPU ready line low. The CPU programs it through an 8-byte register window.

## Interface
Parameters:
- ADDR_LIMIT, 16'hD000, first address DMA may not write (RAM ends at CFFF).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cs  in  1  register window select
- we  in  1  register write enable (CPU_WE)
- rs  in  3  register select (CPU_AB[2:0])
- din  in  8  CPU write data
- dout  out  8  register read data, registered
- irq  out  1  interrupt request, level
- cpu_ab  in  16  CPU address
- cpu_we  in  1  CPU write enable
- cpu_do  in  8  CPU write data
- cpu_rdy  out  1  CPU ready; 0 = stalled
- mem_ab  out  16  address to memory decode
- mem_we  out  1  write enable to memory decode
- mem_do  out  8  write data to memory
- rx_data  in  8  USB rx byte
- rx_val  in  1  USB rx valid
- rx_rdy  out  1  USB rx ready
- acia_rx_val  out  1  rx valid forwarded to ACIA
- acia_rx_rdy  in  1  ACIA rx ready

## Operation
- Registers (rs):
  - 0 ADDR_L, 1 ADDR_H: current write pointer, R/W.
  - 2 LEN_L, 3 LEN_H: remaining byte count, R/W.
  - 4 CTRL: bit0 START (write-1), bit1 IE, bit2 ABORT (write-1). Reads as {5'b0, 0, IE, BUSY}.
  - 5 STATUS: bit0 BUSY, bit6 ERR, bit7 DONE. Any write clears DONE and ERR.
  - 6, 7: read 0.
- Register writes take effect only when cs & we & cpu_rdy. Writes to registers 0-3 while BUSY are ignored.
- States:
  - IDLE: mem_* = cpu_* passthrough; cpu_rdy=1; rx_rdy=acia_rx_rdy; acia_rx_val=rx_val.
  - START written in IDLE:
    - LEN==0 → DONE=1, stay IDLE.
    - ADDR>=ADDR_LIMIT → ERR=1, DONE=1, stay IDLE.
    - otherwise → WAIT, BUSY=1.
  - WAIT: passthrough bus; rx_rdy=1; acia_rx_val=0. On rx_val, latch rx_data into the buffer and go to WRITE.
  - WRITE: cpu_rdy=0; mem_ab=ADDR; mem_we=1; mem_do=buffer; rx_rdy=0. At the edge: ADDR+=1, LEN-=1, go to RESTORE.
  - RESTORE: cpu_rdy=0; mem_ab=cpu_ab held; mem_we=0. This re-reads the stalled CPU address so RAM/ROM output is valid when the CPU resumes. Then:
    - LEN==0 → IDLE, DONE=1.
    - new ADDR>=ADDR_LIMIT → IDLE, ERR=1, DONE=1.
    - else → WAIT.
- ABORT:
  - In WAIT → IDLE next edge, DONE=1, ADDR/LEN hold current values.
  - In WRITE/RESTORE → latched; the pair completes, then IDLE with DONE=1.
  - START and ABORT written together: ABORT wins, stay IDLE.
- Arithmetic: ADDR and LEN are 16-bit. LEN never decrements below 0. ADDR cannot wrap because of the ADDR_LIMIT check.
- irq = IE & DONE.

## Timing
- Reset: state IDLE, ADDR=0, LEN=0, IE=0, DONE=0, ERR=0, dout=0, irq=0, cpu_rdy=1, rx_rdy=acia_rx_rdy, acia_rx_val=rx_val, mem_* = cpu_*.
- dout is valid on the cycle after a cs & !we access (matches other peripherals).
- rx handshake completes on the edge where rx_val & rx_rdy in WAIT.
- Each byte costs exactly 2 stalled CPU cycles (WRITE, RESTORE).
- Peak throughput is 1 byte / 3 clk with rx_val held high.
- cpu_rdy, mem_*, rx_rdy and acia_rx_val are combinational from state and inputs. All register state updates on clk.
- DONE sets on the edge leaving RESTORE (or the START/ABORT edge). irq rises in that same cycle.

## Test plan
- Reset, then read all registers → 0. Set cpu_ab=1234 → mem_ab=1234, cpu_rdy=1. Drive rx_val=1 → acia_rx_val=1.
- ADDR=0200, LEN=0003, IE=1, START; stream A1,B2,C3 with rx_val always high → RAM 0200-0202=A1,B2,C3. cpu_rdy is low for exactly 6 cycles total. After the last RESTORE: ADDR=0203, LEN=0, DONE=1, irq=1.
- START with LEN=0 → no bus steal, DONE=1 next cycle, BUSY never set. Writing STATUS clears DONE and irq.
- ADDR=CFFF, LEN=5; send 2 bytes → only CFFF written, ERR=1, DONE=1, LEN=4. The second byte goes to the ACIA (acia_rx_val=1).
- LEN=10, send 3 bytes, then ABORT while in WAIT → IDLE next edge, LEN=7, DONE=1. ABORT issued during WRITE → that byte is still written before IDLE.
- CPU executing a read loop from RAM during DMA → CPU sees correct data after each stall (RESTORE re-read check). rst asserted mid-WRITE → IDLE, cpu_rdy=1 next cycle.
